// File: rtl/menu_seq_ctrl.sv
// Display-mode sequencer: debounced select button, timed auto-rotate and a
// finish detector that homes the display to the time mode.
module menu_seq_ctrl #(
  parameter int DEB_CYCLES   = 1000000,
  parameter int AUTO_CYCLES  = 200000000,
  parameter int FINISH_LINES = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_select,
  input  logic        auto_en,
  input  logic [31:0] lin,
  output logic [2:0]  mode,
  output logic        mode_change,
  output logic        auto_active,
  output logic        finished
);

  localparam int DEB_W   = $clog2(DEB_CYCLES);
  localparam int DWELL_W = $clog2(AUTO_CYCLES);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(AUTO_CYCLES - 1);
  localparam logic [31:0]        FIN_LIMIT  = 32'(FINISH_LINES);
  localparam logic [0:0]         MANUAL     = 1'b0;
  localparam logic [0:0]         AUTO       = 1'b1;
  localparam logic [2:0]         MODE_TIME  = 3'b001;

  logic               sync_q1;
  logic               sync_q2;
  logic               accepted;
  logic [DEB_W-1:0]   deb_cnt;
  logic               press;
  logic               fin_prev;
  logic               fin_rise;
  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic [DWELL_W-1:0] dwell;
  logic [DWELL_W-1:0] dwell_nxt;
  logic               advance;
  logic               force_home;

  // Left rotation of the one-hot mode; any illegal pattern recovers to time mode.
  function automatic logic [2:0] rotate_mode(input logic [2:0] cur);
    logic [2:0] nxt;
    case (cur)
      3'b001:  nxt = 3'b010;
      3'b010:  nxt = 3'b100;
      3'b100:  nxt = 3'b001;
      default: nxt = MODE_TIME;
    endcase
    return nxt;
  endfunction

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_select;
      sync_q2 <= sync_q1;
    end
  end

  // Debouncer; press fires in the same cycle the accepted level rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_cnt  <= '0;
      accepted <= 1'b0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_q2 != accepted) begin
        if (deb_cnt == DEB_LAST) begin
          accepted <= sync_q2;
          deb_cnt  <= '0;
          press    <= sync_q2;
        end else begin
          deb_cnt <= deb_cnt + DEB_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Finish flag and its delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      finished <= 1'b0;
      fin_prev <= 1'b0;
    end else begin
      finished <= (lin >= FIN_LIMIT);
      fin_prev <= finished;
    end
  end

  assign fin_rise = finished & ~fin_prev;

  // Next-state logic; finish homing overrides any press or dwell tick.
  always_comb begin
    state_nxt  = state;
    dwell_nxt  = dwell;
    advance    = 1'b0;
    force_home = 1'b0;
    if (fin_rise) begin
      force_home = 1'b1;
      state_nxt  = MANUAL;
      dwell_nxt  = '0;
    end else begin
      case (state)
        MANUAL: begin
          advance   = press;
          dwell_nxt = '0;
          if (auto_en) begin
            state_nxt = AUTO;
          end else begin
            state_nxt = MANUAL;
          end
        end
        AUTO: begin
          if (press) begin
            advance   = 1'b1;
            state_nxt = MANUAL;
            dwell_nxt = '0;
          end else if (!auto_en) begin
            state_nxt = MANUAL;
            dwell_nxt = '0;
          end else if (dwell == DWELL_LAST) begin
            advance   = 1'b1;
            dwell_nxt = '0;
          end else begin
            dwell_nxt = dwell + DWELL_W'(1);
          end
        end
        default: begin
          state_nxt = MANUAL;
          dwell_nxt = '0;
        end
      endcase
    end
  end

  // State, dwell counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= MANUAL;
      dwell       <= '0;
      mode        <= MODE_TIME;
      mode_change <= 1'b0;
      auto_active <= 1'b0;
    end else begin
      state       <= state_nxt;
      dwell       <= dwell_nxt;
      auto_active <= (state_nxt == AUTO);
      mode_change <= advance | force_home;
      if (force_home) begin
        mode <= MODE_TIME;
      end else if (advance) begin
        mode <= rotate_mode(mode);
      end else begin
        mode <= mode;
      end
    end
  end

endmodule
